// File: rtl/io_uart.sv
// io_uart: memory-mapped 8N1 UART with a TX FIFO and an optional receiver.
// DATA register at BASE, STATUS register at BASE+1.
// The receiver is present only when macro IO_UART_RX_EN is defined.
module io_uart #(
  parameter logic [15:0] BASE         = 16'h2000,
  parameter int unsigned CLKDIV       = 434,
  parameter int unsigned TXDEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_data_w,
  output logic [15:0] io_data_r,
  input  logic        io_re,
  input  logic        io_we,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int unsigned DEPTH     = 1 << TXDEPTH_LOG2;
  localparam int unsigned CW        = TXDEPTH_LOG2 + 1;
  localparam logic [15:0] STAT_ADDR = BASE + 16'd1;
  localparam logic [15:0] BIT_END   = 16'(CLKDIV - 1);
  localparam logic [15:0] HALF_END  = 16'(CLKDIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  logic       wr_data_sel;
  logic       push;
  logic       pop;
  logic       tx_full;
  logic       tx_idle;
  logic       fifo_empty;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ovr;
  logic       frm_err;
  logic [7:0] unused_w;

  assign unused_w    = io_data_w[15:8];
  assign wr_data_sel = io_we && (io_addr == BASE);

  // TX FIFO storage and control
  logic [7:0]              mem_q [DEPTH];
  logic [TXDEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;

  assign tx_full    = (count_q == CW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  // a pop in the same cycle frees a slot, so a full FIFO still accepts
  assign push       = wr_data_sel && (!tx_full || pop);

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO data array (contents are don't-care while empty)
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= io_data_w[7:0];
  end

  // Transmitter
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_q, tx_d;

  assign uart_tx = tx_q;
  assign tx_idle = (tx_state_q == TX_IDLE) && fifo_empty;

  // TX next state; line level is computed one cycle ahead so it is registered
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          tx_sh_d    = mem_q[rd_ptr_q];
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_DATA;
          tx_d       = tx_sh_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_d     = tx_sh_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  // TX state registers; reset forces the line high immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
    end
  end

`ifdef IO_UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  logic        wr_stat_sel;
  logic        rd_data_sel;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_ovr_q, rx_ovr_d;
  logic        frm_err_q, frm_err_d;
  logic        rx_done;
  logic        rx_ferr;

  assign wr_stat_sel = io_we && (io_addr == STAT_ADDR);
  assign rd_data_sel = io_re && (io_addr == BASE);
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_ovr      = rx_ovr_q;
  assign frm_err     = frm_err_q;

  // two-flop synchronizer plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // RX next state and status flag update
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          rx_done    = rx_s2_q;
          rx_ferr    = !rx_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    // a completing frame overrides a same-cycle DATA read without flagging overrun
    rx_data_d  = rx_done ? rx_sh_q : rx_data_q;
    rx_valid_d = rx_done || (rx_valid_q && !rd_data_sel);
    rx_ovr_d   = (rx_ovr_q && !wr_stat_sel) || (rx_done && rx_valid_q && !rd_data_sel);
    frm_err_d  = (frm_err_q && !wr_stat_sel) || rx_ferr;
  end

  // RX state and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      frm_err_q  <= frm_err_d;
    end
  end
`else
  logic [1:0] unused_rx;

  assign unused_rx = {uart_rx, io_re};
  assign rx_data   = '0;
  assign rx_valid  = 1'b0;
  assign rx_ovr    = 1'b0;
  assign frm_err   = 1'b0;
`endif

  // register read mux, purely combinational from the address
  always_comb begin
    io_data_r = '0;
    if (io_addr == BASE)           io_data_r = {8'h00, rx_data};
    else if (io_addr == STAT_ADDR) io_data_r = {11'b0, frm_err, rx_ovr, rx_valid, tx_idle, tx_full};
  end

endmodule

// File: tb/tb_io_uart.sv
// tb_io_uart: randomized self-checking bench for io_uart (CLKDIV=4, 4-deep FIFO).
// RX checks are compiled when IO_UART_RX_EN is defined; otherwise the bench
// checks that the receiver is absent.
module tb_io_uart;

  localparam int          CLKDIV = 4;
  localparam int          DEPTH  = 4;
  localparam logic [15:0] A_DATA = 16'h2000;
  localparam logic [15:0] A_STAT = 16'h2001;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] io_addr;
  logic [15:0] io_data_w;
  logic [15:0] io_data_r;
  logic        io_re;
  logic        io_we;
  logic        uart_tx;
  logic        uart_rx;

  io_uart #(.BASE(16'h2000), .CLKDIV(CLKDIV), .TXDEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset), .io_addr(io_addr), .io_data_w(io_data_w),
    .io_data_r(io_data_r), .io_re(io_re), .io_we(io_we),
    .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // serial line monitor: records every frame as 10 time-ordered bit levels
  logic        mon_en = 1'b0;
  logic        mon_busy = 1'b0;
  logic [9:0]  frames[$];
  int unsigned shape_bad = 0;

  initial begin : tx_mon
    logic [9:0] fr;
    logic       bad;
    logic       s;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && uart_tx === 1'b0) begin
        mon_busy = 1'b1;
        fr = '0;
        bad = 1'b0;
        for (int i = 1; i < 10 * CLKDIV; i++) begin
          @(negedge clk);
          s = uart_tx;
          if (i % CLKDIV == 0) fr[i / CLKDIV] = s;
          else if (s !== fr[i / CLKDIV]) bad = 1'b1;
        end
        frames.push_back(fr);
        if (bad) shape_bad++;
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // reference: 8N1 frame in line order, start bit first
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  logic [7:0] exp_q[$];
  logic [7:0] bq[$];

  // receiver reference state
  logic       m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
  logic [7:0] m_data = 8'h00;

  function automatic logic [15:0] m_rxbits();
    return {11'b0, m_ferr, m_ovr, m_valid, 2'b00};
  endfunction

  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_data  = b;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic peek(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    io_addr = a;
    #1 d = io_data_r;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    io_addr = a;
    io_re = 1'b1;
    #1 d = io_data_r;
    @(negedge clk);
    io_re = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    io_addr = a;
    io_data_w = d;
    io_we = 1'b1;
    @(negedge clk);
    io_we = 1'b0;
  endtask

  // writes every byte of bq to DATA on consecutive clocks
  task automatic burst_write();
    foreach (bq[i]) begin
      @(negedge clk);
      io_addr = A_DATA;
      io_data_w = {8'h00, bq[i]};
      io_we = 1'b1;
    end
    @(negedge clk);
    io_we = 1'b0;
  endtask

  task automatic wait_tx_done();
    logic [15:0] s;
    logic        done;
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      peek(A_STAT, s);
      if (s[1] && !mon_busy) done = 1'b1;
    end
    if (!done) check("tx_timeout", 16'h0000, 16'h0001);
  endtask

  task automatic check_frames(input string tag);
    check({tag, "_count"}, 16'(frames.size()), 16'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < frames.size(); i++)
      check({tag, "_frame"}, {6'b0, frames[i]}, {6'b0, frame_of(exp_q[i])});
    check({tag, "_shape"}, 16'(shape_bad), 16'h0000);
    frames.delete();
    exp_q.delete();
    shape_bad = 0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      uart_rx = f[k];
      repeat (CLKDIV - 1) @(negedge clk);
    end
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (CLKDIV * 2) @(negedge clk);
  endtask

  initial begin : main
    logic [15:0] s;
    logic [7:0]  b;
    int          n;
    int          lows;

    reset = 1'b1;
    io_addr = '0;
    io_data_w = '0;
    io_re = 1'b0;
    io_we = 1'b0;
    uart_rx = 1'b1;

    repeat (3) @(negedge clk);
    #1 check("rst_tx_line", {15'b0, uart_tx}, 16'h0001);
    peek(A_STAT, s);  check("rst_status", s, 16'h0002);
    peek(A_DATA, s);  check("rst_data", s, 16'h0000);
    peek(16'h2002, s); check("other_addr", s, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;

    // single byte framing
    wr(A_DATA, 16'h00A5);
    exp_q.push_back(8'hA5);
    wait_tx_done();
    check_frames("a5");
    peek(A_STAT, s); check("a5_status", s, 16'h0002);

    // overfill while busy: transmitter takes one byte, FIFO holds DEPTH
    bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    burst_write();
    peek(A_STAT, s); check("full_after_5", s & 16'h0001, 16'h0001);
    wr(A_DATA, 16'h0006);
    peek(A_STAT, s); check("full_after_6", s & 16'h0001, 16'h0001);
    for (int i = 0; i < DEPTH + 1; i++) exp_q.push_back(8'(i + 1));
    wait_tx_done();
    check_frames("burst");
    peek(A_STAT, s); check("burst_status", s, 16'h0002);

    // random bursts, some exceeding capacity
    for (int r = 0; r < 5; r++) begin
      n = (r < 3) ? $urandom_range(1, DEPTH + 1) : DEPTH + 1 + $urandom_range(1, 3);
      bq.delete();
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        bq.push_back(b);
        if (i < DEPTH + 1) exp_q.push_back(b);
      end
      burst_write();
      wait_tx_done();
      check_frames("rand_tx");
    end

`ifdef IO_UART_RX_EN
    // single frame received then read
    send_rx(8'h3C, 1'b1); model_frame(8'h3C, 1'b1);
    peek(A_STAT, s); check("rx3c_status", s & 16'h001C, m_rxbits());
    rd(A_DATA, s);   check("rx3c_data", s, {8'h00, m_data});
    m_valid = 1'b0;
    peek(A_STAT, s); check("rx3c_status2", s & 16'h001C, m_rxbits());

    // overrun
    send_rx(8'h11, 1'b1); model_frame(8'h11, 1'b1);
    send_rx(8'h22, 1'b1); model_frame(8'h22, 1'b1);
    rd(A_DATA, s);   check("ovr_data", s, {8'h00, m_data});
    m_valid = 1'b0;
    peek(A_STAT, s); check("ovr_status", s & 16'h001C, m_rxbits());
    wr(A_STAT, 16'hFFFF); m_ovr = 1'b0; m_ferr = 1'b0;
    peek(A_STAT, s); check("ovr_cleared", s & 16'h001C, m_rxbits());

    // glitch rejection, then framing error
    @(negedge clk); uart_rx = 1'b0;
    @(negedge clk); uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    peek(A_STAT, s); check("glitch_status", s & 16'h001C, m_rxbits());
    send_rx(8'h55, 1'b0); model_frame(8'h55, 1'b0);
    peek(A_STAT, s); check("ferr_status", s & 16'h001C, m_rxbits());
    peek(A_DATA, s); check("ferr_data_kept", s, {8'h00, m_data});
    wr(A_STAT, 16'h0000); m_ovr = 1'b0; m_ferr = 1'b0;
    peek(A_STAT, s); check("ferr_cleared", s & 16'h001C, m_rxbits());

    // random frames with random reads
    for (int r = 0; r < 6; r++) begin
      b = 8'($urandom);
      send_rx(b, 1'b1); model_frame(b, 1'b1);
      peek(A_STAT, s); check("rand_rx_status", s & 16'h001C, m_rxbits());
      if ($urandom_range(0, 1) == 1) begin
        rd(A_DATA, s); check("rand_rx_data", s, {8'h00, m_data});
        m_valid = 1'b0;
      end
    end
`else
    // receiver absent: line activity has no effect
    for (int r = 0; r < 2; r++) send_rx(8'($urandom), 1'b1);
    peek(A_STAT, s); check("norx_status", s & 16'h001C, 16'h0000);
    rd(A_DATA, s);   check("norx_data", s, 16'h0000);
`endif

    // reset during DATA with more bytes queued
    mon_en = 1'b0;
    bq = '{8'h00, 8'hFF, 8'hFF};
    burst_write();
    repeat (8) @(negedge clk);
    #1 check("tx_low_before_rst", {15'b0, uart_tx}, 16'h0000);
    reset = 1'b1;
    #1 check("tx_high_async", {15'b0, uart_tx}, 16'h0001);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    peek(A_STAT, s); check("post_rst_status", s, 16'h0002);
    peek(A_DATA, s); check("post_rst_data", s, 16'h0000);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check("post_rst_quiet", 16'(lows), 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
